uart_tx_port: RTL and testbench

UART_TX_PORT -- requirements
Module: uart_tx_port

---
 rtl/uart_tx_port.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_port.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_port.sv
// Bus-mapped UART transmitter: TXDATA pushes into a small FIFO, and the FSM emits
// 8N1 frames on txd, LSB first. STATUS reports {ovf, 4'b0, busy, empty, full}.
`timescale 1ns/1ps

module uart_tx_port #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        rd,
    input  logic        wr,
    input  logic [12:0] addr,
    inout  wire  [7:0]  data,
    output logic        txd
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [7:0]    BAUD_LAST  = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_reg;
    logic [7:0]    baud_reg;
    logic [2:0]    bit_idx_reg;
    logic [7:0]    shift_reg;
    logic          txd_reg;

    logic [7:0]    mem_reg [DEPTH];
    logic [AW-1:0] head_reg, head_next;
    logic [AW-1:0] tail_reg, tail_next;
    logic [CW-1:0] count_reg, count_next;
    logic          ovf_reg, ovf_next;
    logic          wr_sel_reg;

    logic          wr_sel;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          busy;
    logic          baud_end;
    logic          ovf_clr;
    logic          bus_drive;
    logic [7:0]    status_word;
    logic [7:0]    rd_word;
    logic          addr_unused;

    assign addr_unused = ^addr[12:1];

    always_comb begin
        wr_sel   = en && wr && !addr[0];
        push_req = rst_n && wr_sel && !wr_sel_reg;
        full     = (count_reg == FULL_COUNT);
        empty    = (count_reg == '0);
        busy     = (state_reg != IDLE);
        baud_end = (baud_reg == BAUD_LAST);
        pop      = rst_n && (state_reg == IDLE) && !empty;
        // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
        push     = push_req && (!full || pop);
        ovf_clr  = rst_n && en && wr && addr[0] && data[7];
    end

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg + CW'(push) - CW'(pop);
        ovf_next   = ovf_reg;
        if (pop) begin
            head_next = head_reg + AW'(1);
        end
        if (push) begin
            tail_next = tail_reg + AW'(1);
        end
        if (push_req && !push) begin
            ovf_next = 1'b1;
        end
        if (ovf_clr) begin
            ovf_next = 1'b0;
        end
    end

    // Storage array is left unreset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[tail_reg] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_reg   <= '0;
            tail_reg   <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
            wr_sel_reg <= 1'b0;
        end else begin
            head_reg   <= head_next;
            tail_reg   <= tail_next;
            count_reg  <= count_next;
            ovf_reg    <= ovf_next;
            wr_sel_reg <= wr_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            txd_reg     <= 1'b1;
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    txd_reg     <= 1'b1;
                    baud_reg    <= '0;
                    bit_idx_reg <= '0;
                    if (pop) begin
                        shift_reg <= mem_reg[head_reg];
                        txd_reg   <= 1'b0;
                        state_reg <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_reg    <= '0;
                        bit_idx_reg <= '0;
                        txd_reg     <= shift_reg[0];
                        state_reg   <= DATA;
                    end else begin
                        baud_reg <= baud_reg + 8'd1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_reg <= '0;
                        if (bit_idx_reg == 3'd7) begin
                            txd_reg   <= 1'b1;
                            state_reg <= STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                            shift_reg   <= {1'b0, shift_reg[7:1]};
                            txd_reg     <= shift_reg[1];
                        end
                    end else begin
                        baud_reg <= baud_reg + 8'd1;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_reg  <= '0;
                        txd_reg   <= 1'b1;
                        state_reg <= IDLE;
                    end else begin
                        baud_reg <= baud_reg + 8'd1;
                    end
                end
                default: begin
                    txd_reg   <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign txd = txd_reg;

    // Held in reset the registers may not have settled yet, so report the reset status directly.
    always_comb begin
        status_word = rst_n ? {ovf_reg, 4'b0000, busy, empty, full} : 8'h02;
        rd_word     = addr[0] ? status_word : 8'h00;
        bus_drive   = en && rd;
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bus
            assign data[gi] = bus_drive ? rd_word[gi] : 1'bz;
        end
    endgenerate

endmodule

// File: tb/tb_uart_tx_port.sv
// Randomized and directed bench for uart_tx_port against a queue-based frame model,
// plus an independent serial monitor that decodes txd back into bytes.
`timescale 1ns/1ps

module tb_uart_tx_port;
    localparam int C = 4;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [12:0] addr = '0;
    logic [7:0]  data_drv = '0;
    logic        data_oe = 1'b0;
    wire  [7:0]  data;
    wire         txd;

    assign data = data_oe ? data_drv : 8'hzz;

    always #5 clk = ~clk;

    uart_tx_port #(.CLKS_PER_BIT(C), .DEPTH(D)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .rd   (rd),
        .wr   (wr),
        .addr (addr),
        .data (data),
        .txd  (txd)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus the number of frame cycles still to go.
    logic [7:0] q[$];
    int         frame_left = 0;
    logic [7:0] cur_byte = '0;
    logic       m_ovf = 1'b0;
    logic       m_prev = 1'b0;

    function automatic logic m_txd();
        int pos;
        if (frame_left == 0) return 1'b1;
        pos = (10 * C - frame_left) / C;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return cur_byte[pos-1];
    endfunction

    function automatic logic [7:0] m_status();
        return {m_ovf, 4'b0000, frame_left != 0, q.size() == 0, q.size() == D};
    endfunction

    task automatic model_edge();
        int   sz;
        logic pop_m;
        logic sel;
        if (!rst_n) begin
            q.delete();
            frame_left = 0;
            m_ovf      = 1'b0;
            m_prev     = 1'b0;
        end else begin
            sz    = q.size();
            pop_m = (frame_left == 0) && (sz > 0);
            sel   = en && wr && !addr[0];
            if (pop_m) begin
                cur_byte   = q.pop_front();
                frame_left = 10 * C;
            end else if (frame_left > 0) begin
                frame_left--;
            end
            if (sel && !m_prev) begin
                if (sz < D || pop_m) q.push_back(data_drv);
                else m_ovf = 1'b1;
            end
            if (en && wr && addr[0] && data_drv[7]) m_ovf = 1'b0;
            m_prev = sel;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("txd", txd, m_txd());
        if (en && rd) begin
            if (addr[0]) check("status_rd", data, m_status());
            else check("txdata_rd", data, 8'h00);
        end
    endtask

    // Independent serial decoder: samples mid-bit and collects completed frames.
    logic [7:0] rx_q[$];
    logic       mon_act = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_sh = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            mon_act <= 1'b0;
        end else if (!mon_act) begin
            if (txd == 1'b0) begin
                mon_act <= 1'b1;
                mon_cnt <= 1;
            end
        end else begin
            if (mon_cnt >= C + C / 2 && mon_cnt < 9 * C && ((mon_cnt - C / 2) % C) == 0)
                mon_sh <= {txd, mon_sh[7:1]};
            if (mon_cnt == 10 * C - 1) begin
                mon_act <= 1'b0;
                rx_q.push_back(mon_sh);
            end else begin
                mon_cnt <= mon_cnt + 1;
            end
        end
    end

    task automatic bus_write(input logic a0, input logic [7:0] d, input int hold, input logic en_val);
        en       = en_val;
        wr       = 1'b1;
        rd       = 1'b0;
        addr     = {12'($urandom), a0};
        data_drv = d;
        data_oe  = 1'b1;
        repeat (hold) tick();
        en      = 1'b0;
        wr      = 1'b0;
        data_oe = 1'b0;
        addr    = '0;
        tick();
    endtask

    task automatic bus_read_tick(input logic a0);
        data_oe = 1'b0;
        en      = 1'b1;
        rd      = 1'b1;
        addr    = {12'($urandom), a0};
        tick();
        en = 1'b0;
        rd = 1'b0;
    endtask

    task automatic peek_status(output logic [7:0] v);
        data_oe = 1'b0;
        en      = 1'b1;
        rd      = 1'b1;
        addr    = 13'd1;
        #1;
        v  = data;
        en = 1'b0;
        rd = 1'b0;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 3000 && !(frame_left == 0 && q.size() == 0); i++) tick();
        check("drain_timeout", i < 3000, 1);
    endtask

    task automatic wait_pos(input int pos);
        int i;
        for (i = 0; i < 500 && !(frame_left > 0 && (10 * C - frame_left) / C == pos); i++) tick();
        check("wait_pos_timeout", i < 500, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] st;
        logic       hiz_ok;
        int         pat[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        logic [7:0] ovf_bytes[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        logic [7:0] full_bytes[6] = '{8'hC1, 8'h5E, 8'h07, 8'hF0, 8'h99, 8'h2B};
        int         rx_before;
        int         i;

        // Reset: txd idle high, status reads only empty, even while held in reset.
        rst_n = 1'b0;
        repeat (3) tick();
        peek_status(st);
        check("reset_status", st, 8'h02);
        bus_write(1'b0, 8'hEE, 1, 1'b1);
        bus_read_tick(1'b1);
        rst_n = 1'b1;
        tick();
        peek_status(st);
        check("post_reset_status", st, 8'h02);
        check("post_reset_txd", txd, 1'b1);

        // Bus hygiene.
        data_oe = 1'b0;
        en      = 1'b0;
        rd      = 1'b1;
        addr    = 13'd1;
        #1;
        hiz_ok = $isunknown(data) || (data == 8'h00);
        check("hiz_when_deselected", hiz_ok, 1'b1);
        rd = 1'b0;
        en = 1'b1;
        rd = 1'b1;
        addr = 13'd0;
        #1;
        check("txdata_read_zero", data, 8'h00);
        en = 1'b0;
        rd = 1'b0;
        bus_read_tick(1'b0);

        // Single byte A5: latency, bit pattern, busy drop after 40 cycles.
        rx_q.delete();
        en = 1'b1; wr = 1'b1; addr = 13'd0; data_drv = 8'hA5; data_oe = 1'b1;
        tick();
        check("lat_edge_cycle", txd, 1'b1);
        en = 1'b0; wr = 1'b0; data_oe = 1'b0;
        tick();
        check("lat_start_bit", txd, 1'b0);
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < C; c++) begin
                check("a5_bit", txd, pat[b]);
                tick();
            end
        end
        peek_status(st);
        check("a5_busy_done", st, 8'h02);
        check("a5_rx_count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("a5_rx_byte", rx_q[0], 8'hA5);

        // Held strobe: one frame only.
        rx_q.delete();
        bus_write(1'b0, 8'h3C, 10, 1'b1);
        peek_status(st);
        check("held_status", st, 8'h06);
        drain();
        check("held_rx_count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("held_rx_byte", rx_q[0], 8'h3C);

        // Overflow: six quick writes, sixth dropped.
        rx_q.delete();
        for (i = 0; i < 6; i++) bus_write(1'b0, ovf_bytes[i], 1, 1'b1);
        peek_status(st);
        check("ovf_full_status", st, 8'h85);
        while (rx_q.size() == 0 && frame_left != 0) tick();
        repeat (3) tick();
        peek_status(st);
        check("ovf_status_draining", st, 8'h84);
        bus_write(1'b1, 8'h80, 1, 1'b1);
        peek_status(st);
        check("ovf_cleared", st[7], 1'b0);
        drain();
        check("ovf_rx_count", rx_q.size(), 5);
        for (i = 0; i < 5 && i < rx_q.size(); i++) check("ovf_rx_byte", rx_q[i], ovf_bytes[i]);

        // Full FIFO with a write edge exactly on the IDLE pop cycle.
        rx_q.delete();
        for (i = 0; i < 5; i++) bus_write(1'b0, full_bytes[i], 1, 1'b1);
        for (i = 0; i < 500 && frame_left != 0; i++) tick();
        check("pop_cycle_timeout", i < 500, 1);
        en = 1'b1; wr = 1'b1; addr = 13'd0; data_drv = full_bytes[5]; data_oe = 1'b1;
        tick();
        en = 1'b0; wr = 1'b0; data_oe = 1'b0;
        peek_status(st);
        check("full_pop_status", st, 8'h05);
        drain();
        check("full_rx_count", rx_q.size(), 6);
        for (i = 0; i < 6 && i < rx_q.size(); i++) check("full_rx_byte", rx_q[i], full_bytes[i]);

        // Reset during DATA bit 3 with bytes still queued.
        rx_q.delete();
        bus_write(1'b0, 8'hB7, 1, 1'b1);
        bus_write(1'b0, 8'h48, 1, 1'b1);
        bus_write(1'b0, 8'h9D, 1, 1'b1);
        wait_pos(4);
        rst_n = 1'b0;
        tick();
        check("rst_mid_txd", txd, 1'b1);
        peek_status(st);
        check("rst_mid_status", st, 8'h02);
        tick();
        rst_n = 1'b1;
        rx_before = rx_q.size();
        repeat (120) tick();
        check("rst_no_frames", rx_q.size(), rx_before);
        peek_status(st);
        check("rst_after_status", st, 8'h02);

        // Random traffic against the model.
        for (int it = 0; it < 1200; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: bus_write(1'b0, 8'($urandom), $urandom_range(1, 3), ($urandom_range(0, 7) != 0));
                4:          bus_read_tick(1'b1);
                5:          bus_read_tick(1'b0);
                6:          bus_write(1'b1, 8'($urandom), 1, 1'b1);
                7, 8:       repeat ($urandom_range(1, 60)) tick();
                default: begin
                    if ($urandom_range(0, 9) == 0) begin
                        rst_n = 1'b0;
                        repeat ($urandom_range(1, 3)) tick();
                        rst_n = 1'b1;
                    end else begin
                        tick();
                    end
                end
            endcase
        end
        drain();
        bus_write(1'b1, 8'h80, 1, 1'b1);
        peek_status(st);
        check("final_status", st, 8'h02);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
